pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequencing controller for the fetch-stage program counter register. It arbitrates PC redirect requests from three sources: CSR trap/return, execute-stage branch mispredict and IF-stage predicted jump. It also decides when the PC holds for pipeline hazards, and produces the flush controls for the pipeline registers. It sits between the hazard/CSR logic and the PC register, and owns every decision about when and where the PC moves.

## Interface
- XLEN, 64, PC and target width
- DRAIN_CYCLES, 2, cycles the pipeline drains after a trap before the redirect is issued (0 allowed)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- trap_valid  in  1  CSR unit requests trap entry or xRET
- trap_pc  in  XLEN  trap/return target
- br_mis_valid  in  1  EX-stage branch mispredict
- br_target  in  XLEN  corrected branch target
- if_jump_valid  in  1  IF-stage predicted jump
- if_jump_target  in  XLEN  predicted target
- load_use_hazard  in  1  data hazard stall request
- csr_busy  in  1  CSR multi-cycle stall request
- fetch_ready  in  1  fetch stage accepts a redirect this cycle
- redirect_valid  out  1  PC must load redirect_pc
- redirect_pc  out  XLEN  redirect target
- redirect_src  out  2  0 none, 1 trap, 2 branch, 3 jump
- hold_pc  out  1  PC must keep its value
- flush_front  out  1  flush IF/ID
- flush_all  out  1  flush IF/ID, ID/EX, EX/MEM
- busy  out  1  state is not RUN
- perf_redirects  out  32  redirects completed
- perf_stalls  out  32  cycles with hold_pc=1

## Operation
- States: RUN, DRAIN, REDIRECT.
- Source priority: trap > br_mis > if_jump. Requests are sampled at the rising edge and the winner is latched.
- RUN:
  - hold_pc = load_use_hazard | csr_busy (combinational).
  - trap → DRAIN, or → REDIRECT when DRAIN_CYCLES=0.
  - Otherwise br_mis → REDIRECT.
  - Otherwise if_jump → REDIRECT, only when hold_pc=0. A jump seen during a hazard hold is dropped, because the IF stage re-presents it.
- DRAIN:
  - hold_pc=1, flush_all=1.
  - Down-counter loaded with DRAIN_CYCLES-1; at 0 → REDIRECT.
  - All new requests are ignored.
- REDIRECT:
  - redirect_valid=1; redirect_pc and redirect_src are stable; hold_pc=0.
  - flush_front=1 for branch or jump; flush_all=1 for trap.
  - fetch_ready=1 → RUN next cycle.
  - A trap arriving in REDIRECT preempts a pending branch/jump: the latched target is replaced and the FSM → DRAIN.
  - A branch or jump arriving in REDIRECT is ignored, because it comes from a younger, flushed instruction.
- Reset: state RUN, redirect_valid=0, redirect_pc=0, redirect_src=0, flush_front=0, flush_all=0, busy=0, drain counter 0, perf counters 0. hold_pc = load_use_hazard | csr_busy, because it is combinational in RUN.
- Reset mid-sequence: everything is abandoned immediately.
- Perf counters wrap modulo 2^32.

## Timing
- Branch or jump sampled at edge N: redirect_valid=1 from cycle N+1 and stays high until the cycle with fetch_ready=1 (inclusive). The next cycle is in RUN.
- Trap sampled at N: DRAIN covers N+1 .. N+DRAIN_CYCLES, and redirect_valid rises at N+DRAIN_CYCLES+1.
- Trap and branch sampled at the same edge: trap wins, and the branch is dropped.
- hold_pc is the only combinational output. All other outputs are registered.
- redirect_valid and hold_pc are never asserted together.

## Configuration
- PC_REDIRECT_PERF_EN defined: perf_redirects increments on every cycle with redirect_valid&fetch_ready. perf_stalls increments on every cycle with hold_pc=1.
- Undefined: counters are not built, both ports are tied to 0, and all other behaviour is identical.

## Structure
- Package pc_ctrl_pkg:
  - State enum (RUN, DRAIN, REDIRECT).
  - Source enum (SRC_NONE=0, SRC_TRAP=1, SRC_BR=2, SRC_JMP=3).
  - Perf counter width constant (32).
- Sub-module pc_redirect_prio: combinational fixed-priority picker returning the winning source and target.

## Test plan
- Branch: br_mis_valid at N with target 0x8000_0100 and fetch_ready=1 → redirect_valid=1 and redirect_src=2 at N+1 with flush_front=1; busy=0 at N+2.
- Trap with default DRAIN_CYCLES=2: trap_pc 0x8000_0000 at N → hold_pc=1 and flush_all=1 at N+1 and N+2; redirect_valid=1, redirect_src=1 at N+3.
- Backpressure: branch accepted while fetch_ready=0 for 3 cycles → redirect_valid stays high with a stable target for 4 cycles, then the next cycle is in RUN.
- Preemption: during a branch REDIRECT with fetch_ready=0, trap_valid=1 → next cycle DRAIN with latched target = trap_pc; a later redirect_src=1.
- Hazard plus jump: load_use_hazard=1 together with if_jump_valid=1 → hold_pc=1, no redirect. The same cycle with br_mis_valid=1 instead → REDIRECT next cycle.
- Async reset asserted during DRAIN → all registered outputs 0 and state RUN without waiting for a clock edge. With PC_REDIRECT_PERF_EN defined, perf counters read 0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage PC redirect controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TRAP = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JMP  = 2'd3
    } src_e;

    localparam int PERF_W = 32;

endpackage

// File: rtl/pc_redirect_prio.sv
// Fixed-priority redirect picker: trap over branch mispredict over predicted jump.
module pc_redirect_prio
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    output src_e            src,
    output logic [XLEN-1:0] target
);

    always_comb begin
        src    = SRC_NONE;
        target = '0;
        if (trap_valid) begin
            src    = SRC_TRAP;
            target = trap_pc;
        end else if (br_valid) begin
            src    = SRC_BR;
            target = br_target;
        end else if (jump_valid) begin
            src    = SRC_JMP;
            target = jump_target;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect/hold/flush sequencer for the fetch stage.
// Optional perf counters are built when PC_REDIRECT_PERF_EN is defined.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              br_mis_valid,
    input  logic [XLEN-1:0]   br_target,
    input  logic              if_jump_valid,
    input  logic [XLEN-1:0]   if_jump_target,
    input  logic              load_use_hazard,
    input  logic              csr_busy,
    input  logic              fetch_ready,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        redirect_src,
    output logic              hold_pc,
    output logic              flush_front,
    output logic              flush_all,
    output logic              busy,
    output logic [PERF_W-1:0] perf_redirects,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam int CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    state_e            state, state_next;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_next;
    logic [XLEN-1:0]   pc_q, pc_next;
    src_e              src_q, src_next;
    logic              hazard;
    src_e              pick_src;
    logic [XLEN-1:0]   pick_pc;

    assign hazard = load_use_hazard | csr_busy;

    // A jump seen under a hazard hold is dropped; IF presents it again later.
    pc_redirect_prio #(.XLEN(XLEN)) u_prio (
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .br_valid    (br_mis_valid),
        .br_target   (br_target),
        .jump_valid  (if_jump_valid & ~hazard),
        .jump_target (if_jump_target),
        .src         (pick_src),
        .target      (pick_pc)
    );

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_next        = pc_q;
        src_next       = src_q;
        hold_pc        = 1'b0;
        case (state)
            RUN: begin
                hold_pc = hazard;
                if (pick_src != SRC_NONE) begin
                    pc_next    = pick_pc;
                    src_next   = pick_src;
                    state_next = REDIRECT;
                    if (pick_src == SRC_TRAP && DRAIN_CYCLES > 0) begin
                        state_next     = DRAIN;
                        drain_cnt_next = CNT_W'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                hold_pc = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = REDIRECT;
                end else begin
                    drain_cnt_next = drain_cnt - 1'b1;
                end
            end
            REDIRECT: begin
                // Only a trap may preempt; younger branches/jumps are being flushed.
                if (pick_src == SRC_TRAP) begin
                    pc_next  = pick_pc;
                    src_next = SRC_TRAP;
                    if (DRAIN_CYCLES > 0) begin
                        state_next     = DRAIN;
                        drain_cnt_next = CNT_W'(DRAIN_LOAD);
                    end
                end else if (fetch_ready) begin
                    state_next = RUN;
                    src_next   = SRC_NONE;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            drain_cnt      <= '0;
            pc_q           <= '0;
            src_q          <= SRC_NONE;
            redirect_valid <= 1'b0;
            flush_front    <= 1'b0;
            flush_all      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            drain_cnt      <= drain_cnt_next;
            pc_q           <= pc_next;
            src_q          <= src_next;
            redirect_valid <= (state_next == REDIRECT);
            flush_front    <= (state_next == REDIRECT) && (src_next != SRC_TRAP);
            flush_all      <= (state_next == DRAIN) ||
                              ((state_next == REDIRECT) && (src_next == SRC_TRAP));
            busy           <= (state_next != RUN);
        end
    end

    assign redirect_pc  = pc_q;
    assign redirect_src = src_q;

`ifdef PC_REDIRECT_PERF_EN
    logic [PERF_W-1:0] redir_cnt, stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (redirect_valid && fetch_ready) redir_cnt <= redir_cnt + 1'b1;
            if (hold_pc) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_redirects = redir_cnt;
    assign perf_stalls    = stall_cnt;
`else
    assign perf_redirects = '0;
    assign perf_stalls    = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic
// against a behavioural model of pending redirect plus drain countdown.
module tb_pc_redirect_ctrl;

    localparam int XLEN = 64;
    localparam int DC   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trap_valid = 1'b0;
    logic [XLEN-1:0] trap_pc = '0;
    logic            br_mis_valid = 1'b0;
    logic [XLEN-1:0] br_target = '0;
    logic            if_jump_valid = 1'b0;
    logic [XLEN-1:0] if_jump_target = '0;
    logic            load_use_hazard = 1'b0;
    logic            csr_busy = 1'b0;
    logic            fetch_ready = 1'b0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      redirect_src;
    logic            hold_pc;
    logic            flush_front;
    logic            flush_all;
    logic            busy;
    logic [31:0]     perf_redirects;
    logic [31:0]     perf_stalls;

    pc_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DC)) dut (
        .clk             (clk),
        .rst             (rst),
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .br_mis_valid    (br_mis_valid),
        .br_target       (br_target),
        .if_jump_valid   (if_jump_valid),
        .if_jump_target  (if_jump_target),
        .load_use_hazard (load_use_hazard),
        .csr_busy        (csr_busy),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_src    (redirect_src),
        .hold_pc         (hold_pc),
        .flush_front     (flush_front),
        .flush_all       (flush_all),
        .busy            (busy),
        .perf_redirects  (perf_redirects),
        .perf_stalls     (perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            hold, valid, ff, fa, bsy;
        logic [XLEN-1:0] pc;
        logic [1:0]      src;
        logic [31:0]     pr, ps;
    } exp_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [1:0]      src;
    } txn_t;

    exp_t exp_q[$];
    txn_t txn_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a pending redirect (target/source) and the drain cycles still to run.
    bit              m_pend = 0;
    logic [XLEN-1:0] m_pc   = '0;
    int              m_src  = 0;
    int              m_drain = 0;
    int unsigned     m_pr = 0, m_ps = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_pc = '0; m_src = 0; m_drain = 0; m_pr = 0; m_ps = 0;
    endtask

    task automatic model_step(input bit tv, input logic [XLEN-1:0] tpc, input bit bv,
                              input logic [XLEN-1:0] bt, input bit jv, input logic [XLEN-1:0] jt,
                              input bit lu, input bit cb, input bit fr);
        exp_t e;
        txn_t t;
        bit draining, redir;
        draining = (m_drain > 0);
        redir    = m_pend && !draining;
        e.hold  = draining ? 1'b1 : (redir ? 1'b0 : (lu | cb));
        e.valid = redir;
        e.fa    = draining | (redir && m_src == 1);
        e.ff    = redir && m_src != 1;
        e.bsy   = draining | redir;
        e.pc    = m_pc;
        e.src   = 2'(m_src);
`ifdef PC_REDIRECT_PERF_EN
        e.pr = m_pr;
        e.ps = m_ps;
`else
        e.pr = '0;
        e.ps = '0;
`endif
        exp_q.push_back(e);
        if (redir && fr) begin
            t.pc = m_pc;
            t.src = 2'(m_src);
            txn_q.push_back(t);
            m_pr++;
        end
        if (e.hold) m_ps++;
        if (draining) begin
            m_drain--;
        end else if (tv) begin
            m_pend = 1; m_pc = tpc; m_src = 1; m_drain = DC;
        end else if (redir) begin
            if (fr) m_pend = 0;
        end else if (bv) begin
            m_pend = 1; m_pc = bt; m_src = 2;
        end else if (jv && !(lu | cb)) begin
            m_pend = 1; m_pc = jt; m_src = 3;
        end
    endtask

    task automatic cycle(input bit tv, input logic [XLEN-1:0] tpc, input bit bv,
                         input logic [XLEN-1:0] bt, input bit jv, input logic [XLEN-1:0] jt,
                         input bit lu, input bit cb, input bit fr);
        @(posedge clk);
        #1;
        trap_valid = tv; trap_pc = tpc; br_mis_valid = bv; br_target = bt;
        if_jump_valid = jv; if_jump_target = jt; load_use_hazard = lu; csr_busy = cb;
        fetch_ready = fr;
        model_step(tv, tpc, bv, bt, jv, jt, lu, cb, fr);
    endtask

    task automatic idle(input bit fr);
        cycle(0, '0, 0, '0, 0, '0, 0, 0, fr);
    endtask

    task automatic check_reset_outputs();
        chk("rst_redirect_valid", {63'd0, redirect_valid}, '0);
        chk("rst_redirect_pc", redirect_pc, '0);
        chk("rst_redirect_src", {62'd0, redirect_src}, '0);
        chk("rst_flush_front", {63'd0, flush_front}, '0);
        chk("rst_flush_all", {63'd0, flush_all}, '0);
        chk("rst_busy", {63'd0, busy}, '0);
        chk("rst_hold_pc", {63'd0, hold_pc}, '0);
        chk("rst_perf_redirects", {32'd0, perf_redirects}, '0);
        chk("rst_perf_stalls", {32'd0, perf_stalls}, '0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        trap_valid = 0; br_mis_valid = 0; if_jump_valid = 0;
        load_use_hazard = 0; csr_busy = 0; fetch_ready = 0;
        rst = 1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        txn_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Monitor: per-cycle output check and accepted-redirect transaction check.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hold_pc", {63'd0, hold_pc}, {63'd0, e.hold});
            chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.valid});
            chk("flush_front", {63'd0, flush_front}, {63'd0, e.ff});
            chk("flush_all", {63'd0, flush_all}, {63'd0, e.fa});
            chk("busy", {63'd0, busy}, {63'd0, e.bsy});
            chk("perf_redirects", {32'd0, perf_redirects}, {32'd0, e.pr});
            chk("perf_stalls", {32'd0, perf_stalls}, {32'd0, e.ps});
            if (e.valid) begin
                chk("redirect_pc", redirect_pc, e.pc);
                chk("redirect_src", {62'd0, redirect_src}, {62'd0, e.src});
            end
        end
        if (!rst && redirect_valid && fetch_ready) begin
            if (txn_q.size() == 0) begin
                chk("txn_unexpected", {63'd0, redirect_valid}, '0);
            end else begin
                txn_t t;
                t = txn_q.pop_front();
                chk("txn_pc", redirect_pc, t.pc);
                chk("txn_src", {62'd0, redirect_src}, {62'd0, t.src});
            end
        end
    end

    initial begin
        logic [XLEN-1:0] a, b, c;
        #1;
        check_reset_outputs();
        load_use_hazard = 1;
        #1;
        chk("rst_hold_comb", {63'd0, hold_pc}, 64'd1);
        load_use_hazard = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Branch with immediate acceptance.
        cycle(0, '0, 1, 64'h8000_0100, 0, '0, 0, 0, 1);
        idle(1); idle(1);
        // Trap with drain.
        cycle(1, 64'h8000_0000, 0, '0, 0, '0, 0, 0, 1);
        repeat (4) idle(1);
        // Branch under backpressure.
        cycle(0, '0, 1, 64'h1234_5678_9abc_def0, 0, '0, 0, 0, 0);
        repeat (3) idle(0);
        idle(1); idle(1);
        // Trap preempts pending branch.
        cycle(0, '0, 1, 64'h4000, 0, '0, 0, 0, 0);
        cycle(1, 64'h8000_0200, 0, '0, 0, '0, 0, 0, 0);
        repeat (4) idle(1);
        // Trap and branch together: trap wins.
        cycle(1, 64'h8000_0300, 1, 64'h5000, 0, '0, 0, 0, 1);
        repeat (4) idle(1);
        // Hazard drops the jump, but not a branch.
        cycle(0, '0, 0, '0, 1, 64'h6000, 1, 0, 1);
        idle(1);
        cycle(0, '0, 1, 64'h7000, 0, '0, 1, 0, 0);
        idle(1); idle(1);
        // Jump with no hazard.
        cycle(0, '0, 0, '0, 1, 64'h9000, 0, 0, 1);
        idle(1); idle(1);
        // Async reset mid-drain.
        cycle(1, 64'h8000_0400, 0, '0, 0, '0, 0, 0, 1);
        idle(1);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            cycle($urandom_range(0, 99) < 4, a,
                  $urandom_range(0, 99) < 15, b,
                  $urandom_range(0, 99) < 25, c,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 60);
        end
        repeat (DC + 4) idle(1);
        @(negedge clk);
        #1;
        chk("exp_queue_drained", 64'(exp_q.size()), '0);
        chk("txn_queue_drained", 64'(txn_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
